load_extend_unit: RTL
=====================

Name: load_extend_unit

Overview:
- Read-side counterpart of the store byte-enable path in the multi-cycle CPU.
- Accepts a load request from the control FSM (address plus load type) and checks alignment.
- Issues a word-aligned read to data memory using a req/ack handshake, then extracts the addressed byte or halfword from the returned word.
- Sign- or zero-extends the result to 32 bits and presents it, with a one-cycle done pulse, for write-back into the register file.

Parameters:
- TIMEOUT, 16, number of cycles mem_req may stay high without mem_ack before a bus error is declared; 0 disables the timeout.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- reset  input  1  synchronous reset, active-low.
- ld_start  input  1  load request; sampled only in IDLE.
- ld_addr  input  32  byte address of the load.
- ld_op  input  3  load type: 000 lw, 001 lbu, 010 lb, 011 lhu, 100 lh; 101-111 reserved.
- ld_busy  output  1  high in every state other than IDLE.
- ld_done  output  1  one-cycle completion pulse, asserted on success or error.
- ld_data  output  32  extended load result; holds its value until the next successful done.
- ld_err  output  1  qualifies ld_done; high means the load failed.
- ld_errcode  output  2  01 misaligned, 10 reserved op, 11 bus timeout, 00 none.
- mem_req  output  1  memory read request.
- mem_addr  output  32  word address {addr[31:2],2'b00}.
- mem_rdata  input  32  memory read word; valid when mem_ack is high.
- mem_ack  input  1  read acknowledge.

Behaviour:
- Reset: while reset is low at a rising edge, the FSM goes to IDLE. All outputs become 0: ld_busy, ld_done, ld_data, ld_err, ld_errcode, mem_req, mem_addr. The timeout counter clears.
- Reset mid-transaction: abandons the transaction, with no done pulse. mem_req is low from the cycle after the reset edge.
- States: IDLE, REQ, DONE, ERR.
- IDLE:
  - On ld_start, latch ld_addr and ld_op.
  - Reserved op: go to ERR with code 10.
  - Misaligned access: go to ERR with code 01. Misaligned means lw with addr[1:0]!=0, or lh/lhu with addr[0]!=0. Byte loads are never misaligned.
  - Otherwise go to REQ.
  - An error detected here never asserts mem_req.
- REQ:
  - mem_req=1 and mem_addr is stable for the whole state.
  - On a cycle where mem_ack=1, capture mem_rdata and go to DONE. An ack in the first REQ cycle is legal.
  - The counter increments on each REQ cycle without ack. If TIMEOUT!=0 and the counter reaches TIMEOUT, go to ERR with code 11 and drop mem_req.
  - mem_ack outside REQ is ignored.
- DONE:
  - For one cycle: ld_done=1, ld_err=0, ld_errcode=00, and ld_data is updated.
  - Next state is IDLE.
- ERR:
  - For one cycle: ld_done=1, ld_err=1, ld_errcode set. ld_data is unchanged.
  - Next state is IDLE.
- Minimum latency: start at cycle 0, mem_req in cycle 1, ack in cycle 1, done in cycle 2. An error detected in IDLE gives done in cycle 1.
- ld_start while busy is ignored, not queued. ld_start in the DONE/ERR cycle is also ignored; a new request is accepted only in the following IDLE cycle.
- Extraction is little-endian, with A = latched addr[1:0]:
  - Byte: lane A is bits [8A+7:8A].
  - Halfword: A[1]=0 selects [15:0]; A[1]=1 selects [31:16].
  - lw: the full word, unchanged.
- Extension: lbu/lhu zero-fill. lb/lh replicate bit 7 / bit 15 of the extracted value.

Test Plan:
- lw at 0x100, ack in the same cycle as mem_req, rdata 0xDEADBEEF -> mem_addr=0x100, ld_done in cycle 2, ld_data=0xDEADBEEF, ld_err=0.
- rdata 0x80FF7F01, lb at 0x203 -> 0xFFFFFF80; lbu at 0x202 -> 0x000000FF; lb at 0x200 -> 0x00000001; mem_addr=0x200 in all cases.
- rdata 0x8001F00F: lh at 0x12 -> 0xFFFF8001; lhu at 0x10 -> 0x0000F00F; lh at 0x10 -> 0xFFFFF00F.
- lw at 0x101, lh at 0x103, and op 110 -> no mem_req; ld_done in cycle 1 with ld_err=1 and ld_errcode 01/01/10; ld_data keeps its previous value.
- TIMEOUT=4, mem_ack held low -> mem_req high for exactly 4 cycles, then ld_done with ld_errcode=11. A late ack afterwards is ignored.
- reset driven low during REQ with ld_start pulsed while busy -> mem_req=0 and all outputs 0 after the reset edge, no done pulse. A fresh lbu afterwards completes normally.

Source files
------------

// File: rtl/load_extend_unit.sv
// load_extend_unit: aligned word read over req/ack, then byte/halfword extraction with sign/zero extension
module load_extend_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ld_start,
    input  logic [31:0] ld_addr,
    input  logic [2:0]  ld_op,
    output logic        ld_busy,
    output logic        ld_done,
    output logic [31:0] ld_data,
    output logic        ld_err,
    output logic [1:0]  ld_errcode,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);
    localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

    state_t          state, state_n;
    logic [31:0]     addr_q;
    logic [2:0]      op_q;
    logic [1:0]      code_q, code_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic            bad_op, misal;
    logic [7:0]      lane;
    logic [15:0]     half;
    logic [31:0]     ext;

    // next state: request checks in IDLE, ack or timeout in REQ, single-cycle DONE/ERR
    always_comb begin
        bad_op  = ld_op > 3'd4;
        misal   = (ld_op == 3'd0 && ld_addr[1:0] != 2'b00) || ((ld_op == 3'd3 || ld_op == 3'd4) && ld_addr[0]);
        cnt_n   = cnt + 1'b1;
        state_n = state;
        code_n  = code_q;
        case (state)
            IDLE: if (ld_start) begin
                state_n = (bad_op || misal) ? ERR : REQ;
                code_n  = bad_op ? 2'b10 : 2'b01;
            end
            REQ: if (mem_ack) state_n = DONE;
                 else if (TIMEOUT != 0 && cnt_n == CW'(TIMEOUT)) begin
                     state_n = ERR;
                     code_n  = 2'b11;
                 end
            default: state_n = IDLE;
        endcase
    end

    // little-endian lane selection and extension of the returned word
    always_comb begin
        lane = addr_q[1] ? (addr_q[0] ? mem_rdata[31:24] : mem_rdata[23:16])
                         : (addr_q[0] ? mem_rdata[15:8]  : mem_rdata[7:0]);
        half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        ext  = op_q == 3'd1 ? {24'h0, lane} :
               op_q == 3'd2 ? {{24{lane[7]}}, lane} :
               op_q == 3'd3 ? {16'h0, half} :
               op_q == 3'd4 ? {{16{half[15]}}, half} : mem_rdata;
    end

    // state, request latch, timeout counter and result register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            addr_q  <= '0;
            op_q    <= '0;
            code_q  <= '0;
            cnt     <= '0;
            ld_data <= '0;
        end else begin
            state  <= state_n;
            code_q <= code_n;
            cnt    <= state == REQ ? cnt_n : '0;
            if (state == IDLE && ld_start) begin
                addr_q <= ld_addr;
                op_q   <= ld_op;
            end
            if (state == REQ && mem_ack) ld_data <= ext;
        end
    end

    assign ld_busy    = state != IDLE;
    assign ld_done    = state == DONE || state == ERR;
    assign ld_err     = state == ERR;
    assign ld_errcode = state == ERR ? code_q : 2'b00;
    assign mem_req    = state == REQ;
    assign mem_addr   = {addr_q[31:2], 2'b00};
endmodule
